// File: rtl/predictor_table.sv
// Table of saturating direction counters with optional gshare indexing.
// Prediction reads the pre-update counter, so a same-edge result never affects it.
module predictor_table #(
  parameter int CTR_WIDTH   = 2,
  parameter int INDEX_WIDTH = 4,
  parameter int HIST_WIDTH  = 4,
  parameter bit GSHARE      = 1'b0,
  parameter logic [CTR_WIDTH-1:0] INIT = {CTR_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   request,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic                   result,
  input  logic [INDEX_WIDTH-1:0] res_index,
  input  logic                   taken,
  output logic                   prediction,
  output logic                   pred_valid
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

  logic [CTR_WIDTH-1:0]   r_ctr [DEPTH];
  logic [HIST_WIDTH-1:0]  r_ghr;
  logic [INDEX_WIDTH-1:0] w_hist_ext;
  logic [INDEX_WIDTH-1:0] w_req_eff;
  logic [INDEX_WIDTH-1:0] w_res_eff;
  logic [CTR_WIDTH-1:0]   w_res_ctr;
  logic [CTR_WIDTH-1:0]   w_res_next;

  // History is kept in bimodal mode too; it just does not feed the index.
  assign w_hist_ext = GSHARE ? INDEX_WIDTH'(r_ghr) : '0;
  assign w_req_eff  = req_index ^ w_hist_ext;
  assign w_res_eff  = res_index ^ w_hist_ext;
  assign w_res_ctr  = r_ctr[w_res_eff];

  always_comb begin
    w_res_next = w_res_ctr;
    if (taken && (w_res_ctr != CTR_MAX)) begin
      w_res_next = w_res_ctr + CTR_WIDTH'(1);
    end else if (!taken && (w_res_ctr != '0)) begin
      w_res_next = w_res_ctr - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= INIT;
      end
    end else if (result) begin
      r_ctr[w_res_eff] <= w_res_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (result) begin
      r_ghr <= HIST_WIDTH'({r_ghr, taken});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prediction <= 1'b0;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= request;
      if (request) begin
        prediction <= r_ctr[w_req_eff][CTR_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_predictor_table.sv
// Scoreboard bench: a bimodal 2-bit instance and a gshare 3-bit instance share
// stimulus; expectations come from a table-of-integers model of the predictor.
module tb_predictor_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       request = 1'b0;
  logic       result = 1'b0;
  logic       taken = 1'b0;
  logic [3:0] reqIndex = '0;
  logic [3:0] resIndex = '0;
  logic       pred0, pv0, pred1, pv1;

  int checkCount = 0;
  int passCount  = 0;

  bit q0[$];
  bit q1[$];
  int ctr0[16];
  int ctr1[16];
  int hist;
  bit lastP0, lastP1;

  always #5 clk = ~clk;

  predictor_table dut0 (
    .clk(clk), .rst(rst), .request(request), .req_index(reqIndex),
    .result(result), .res_index(resIndex), .taken(taken),
    .prediction(pred0), .pred_valid(pv0)
  );

  predictor_table #(.CTR_WIDTH(3), .INDEX_WIDTH(4), .HIST_WIDTH(4), .GSHARE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .request(request), .req_index(reqIndex),
    .result(result), .res_index(resIndex), .taken(taken),
    .prediction(pred1), .pred_valid(pv1)
  );

  task automatic check(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      ctr0[i] = 3;
      ctr1[i] = 7;
    end
    hist = 0;
  endfunction

  function automatic int bump(input int v, input bit up, input int maxVal);
    if (up) return (v < maxVal) ? v + 1 : maxVal;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic applyStimulus(input bit req, input int rIdx, input bit res, input int sIdx, input bit tk);
    int g1Req, g1Res;
    @(posedge clk); #2;
    request  = req;
    reqIndex = 4'(rIdx);
    result   = res;
    resIndex = 4'(sIdx);
    taken    = tk;
    g1Req = (rIdx ^ hist) & 15;
    g1Res = (sIdx ^ hist) & 15;
    if (req) begin
      q0.push_back(ctr0[rIdx] >= 2);
      q1.push_back(ctr1[g1Req] >= 4);
    end
    if (res) begin
      ctr0[sIdx]  = bump(ctr0[sIdx], tk, 3);
      ctr1[g1Res] = bump(ctr1[g1Res], tk, 7);
      hist = ((hist << 1) | int'(tk)) & 15;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, $urandom_range(0, 15), 1'b0, 0, 1'b0);
    @(posedge clk); #2;
    request = 1'b0;
    result  = 1'b0;
    check("pre-reset dut0 pred_valid", pv0, 1);
    #2;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    modelReset();
    #1;
    check("async reset dut0 pred_valid", pv0, 0);
    check("async reset dut0 prediction", pred0, 0);
    check("async reset dut1 pred_valid", pv1, 0);
    check("async reset dut1 prediction", pred1, 0);
    repeat (3) begin
      @(posedge clk); #2;
      request  = 1'b1;
      result   = 1'b1;
      reqIndex = 4'($urandom);
      resIndex = 4'($urandom);
      taken    = 1'($urandom);
    end
    @(posedge clk); #2;
    rst     = 1'b0;
    request = 1'b0;
    result  = 1'b0;
  endtask

  // Monitor: pops one expectation per fresh prediction, otherwise checks hold.
  initial begin : monitor
    bit e;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        lastP0 = 1'b0;
        lastP1 = 1'b0;
      end else begin
        check("dut0 pred_valid", pv0, int'(q0.size() != 0));
        if (q0.size() != 0) begin
          e = q0.pop_front();
          if (pv0) begin
            check("dut0 prediction", pred0, e);
            lastP0 = e;
          end
        end else if (!pv0) check("dut0 hold", pred0, lastP0);
        check("dut1 pred_valid", pv1, int'(q1.size() != 0));
        if (q1.size() != 0) begin
          e = q1.pop_front();
          if (pv1) begin
            check("dut1 prediction", pred1, e);
            lastP1 = e;
          end
        end else if (!pv1) check("dut1 hold", pred1, lastP1);
      end
    end
  end

  initial begin : driver
    modelReset();
    #1;
    check("reset dut0 pred_valid", pv0, 0);
    check("reset dut0 prediction", pred0, 0);
    check("reset dut1 pred_valid", pv1, 0);
    check("reset dut1 prediction", pred1, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    applyStimulus(1'b1, 3, 1'b0, 0, 1'b0);

    repeat (3) applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
    applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 5, 1'b0);
    applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);
    repeat (2) applyStimulus(1'b0, 0, 1'b1, 5, 1'b1);
    applyStimulus(1'b1, 5, 1'b0, 0, 1'b0);

    applyStimulus(1'b0, 0, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 7, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 7, 1'b0, 0, 1'b0);

    doReset();
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 0, 1'b1);
    check("ghr model after 1,0,1,1", hist, 11);
    applyStimulus(1'b1, 11, 1'b0, 0, 1'b0);

    doReset();
    repeat (8) applyStimulus(1'b0, 0, 1'b1, 2, 1'b1);
    repeat (4) applyStimulus(1'b0, 0, 1'b1, 2, 1'b0);
    applyStimulus(1'b1, 2, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 2 ^ hist, 1'b0, 0, 1'b0);

    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i, 1'b0, 0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 79) == 0) doReset();
      else applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                         $urandom_range(0, 2) != 0, $urandom_range(0, 15),
                         1'($urandom));
    end

    repeat (3) applyStimulus(1'b0, 0, 1'b0, 0, 1'b0);
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
